uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Memory-mapped UART transmitter with a byte FIFO, hung off the data-memory I/O decode next to the LED/GPIO registers on `clk0`. The core's store path pushes bytes and polls status through a simple word-register port; the block serialises them 8N1 on a single output pin. It is the downstream consumer of CPU store traffic to the UART address window, and it gives firmware a debug console without touching the frame buffer.

## Interface
- `CLK_HZ`, 25000000, input clock frequency in Hz
- `BAUD`, 115200, line rate; bit period `DIV = CLK_HZ / BAUD` (integer truncation, 217 at defaults, must be ≥ 2)
- `DEPTH`, 16, FIFO entries; power of two, 2..256

- `clk` in 1: system clock (`clk0`); all logic on rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `we` in 1: register write strobe, single-cycle
- `re` in 1: register read strobe, single-cycle
- `addr` in 1: word select; 0 = TXDATA, 1 = STATUS
- `wdata` in 32: write data
- `rdata` out 32: read data, registered
- `uart_tx` out 1: serial line, idle high

## Operation
- TXDATA write: push `wdata[7:0]` if FIFO not full at that edge; if full, drop byte and set `ovf`. Read of TXDATA returns 0.
- STATUS read: bit0 `full`, bit1 `empty`, bit2 `busy` (state ≠ IDLE or FIFO non-empty), bit3 `ovf` (sticky), bits[15:8] `count` (entries in FIFO, 0..DEPTH), others 0.
- STATUS write: `wdata[3]` = 1 clears `ovf`; other bits ignored. Clear and a same-cycle overflow: overflow wins, `ovf` stays 1.
- FIFO: circular, read/write pointers one bit wider than log2(DEPTH); full when pointers differ only in MSB. Push accepted or rejected on pre-edge `full`; push and pop in the same cycle when full: push dropped, pop proceeds. Push and pop same cycle when neither blocked: `count` unchanged.
- Frame: 8N1, LSB first — start (0), d0..d7, stop (1). Each bit held exactly `DIV` cycles by a baud counter reset at every bit boundary.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `uart_tx`=1; if FIFO non-empty, pop into shift register, go START.
  - START: `uart_tx`=0 for DIV cycles, go DATA with bit index 0.
  - DATA: `uart_tx`=shift[0]; every DIV cycles shift right, index+1; after index 7 completes go STOP.
  - STOP: `uart_tx`=1 for DIV cycles; at end, if FIFO non-empty pop and go START directly (no idle gap), else IDLE.
- `uart_tx` is driven from a flop (no combinational glitch).

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, `uart_tx`=1, `rdata`=0, FIFO empty (pointers 0), `count`=0, `ovf`=0, baud counter 0, shift register 0. Reset mid-frame aborts the frame: line high on the following edge, queued bytes discarded.
- Write at edge N: `count` reflects it at N+1; if block was IDLE with empty FIFO, pop at N+1, `uart_tx` falls at N+2.
- `rdata` valid the edge after `re`; holds last value when `re`=0. STATUS reflects state as of the `re` edge (pre-update).
- Frame length 10·DIV cycles; back-to-back frames abut exactly.
- `re` and `we` same cycle: both act; read returns pre-write value.

## Test plan
- Reset: hold `rst_n`=0 3 cycles -> `uart_tx`=1, STATUS read = 0x00000002 (empty only).
- Single byte: write TXDATA=0x55 at N -> `uart_tx` low at N+2 for 217 cycles, then 1,0,1,0,1,0,1,0 each 217 cycles, stop high 217; `busy` clears at N+2+2170.
- Back-to-back: write 0xA5, 0x0F on consecutive cycles -> two frames, second start bit begins exactly 2170 cycles after first; no idle cycle between stop and start.
- Overflow: while line busy, write 17 bytes with DEPTH=16 and first already popped -> count=16, `full`=1, next write sets `ovf`; STATUS bits3/0 = 1; write STATUS 0x8 -> `ovf`=0, data order preserved on line.
- Full simultaneous push/pop: FIFO full, push coincides with STOP-end pop -> count 15, `ovf`=1, dropped byte never transmitted.
- Reset mid-frame: `rst_n`=0 during d3 of a frame with 4 queued bytes -> `uart_tx`=1 next edge, count=0, no further frames after release.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Memory-mapped 8N1 UART transmitter with a circular byte FIFO.
// TXDATA pushes bytes into the FIFO, and STATUS reports full/empty/busy/ovf/count.
module uart_tx_fifo #(
  parameter int CLK_HZ = 25000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic        re,
  input  logic        addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        uart_tx
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DIV);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   baud_reg, baud_next;
  logic [2:0]      idx_reg, idx_next;
  logic [AW:0]     wr_ptr_reg, rd_ptr_reg;
  logic [7:0]      shift_reg;
  logic            tx_reg, tx_next;
  logic            ovf_reg;
  logic [31:0]     rdata_reg;
  logic [7:0]      mem [DEPTH];

  logic            full, empty, busy, bit_end;
  logic            push, push_drop, ovf_clr, pop, shift_en;
  logic [AW:0]     count;
  logic [8:0]      count_ext;
  logic [31:0]     status;
  logic            unused_bits;

  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign count   = wr_ptr_reg - rd_ptr_reg;
  assign count_ext = 9'(count);
  assign busy    = (state_reg != IDLE) || !empty;
  assign bit_end = (baud_reg == CW'(DIV - 1));

  // Push acceptance is decided on the pre-edge full flag, so a push that
  // coincides with a pop on a full FIFO is dropped.
  assign push      = we && !addr && !full;
  assign push_drop = we && !addr && full;
  assign ovf_clr   = we && addr && wdata[3];

  assign unused_bits = ^{wdata[31:8], count_ext[8]};

  always_comb begin
    status        = '0;
    status[0]     = full;
    status[1]     = empty;
    status[2]     = busy;
    status[3]     = ovf_reg;
    status[15:8]  = count_ext[7:0];
  end

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    idx_next   = idx_reg;
    pop        = 1'b0;
    shift_en   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = START;
          baud_next  = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          idx_next   = 3'd0;
          baud_next  = '0;
        end else begin
          baud_next = baud_reg + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_en  = 1'b1;
          baud_next = '0;
          idx_next  = idx_reg + 3'd1;
          if (idx_reg == 3'd7) state_next = STOP;
        end else begin
          baud_next = baud_reg + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_next = '0;
          // Chain straight into the next start bit so frames abut.
          if (!empty) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The line is registered from the current state, so it trails the FSM by one cycle.
  always_comb begin
    tx_next = 1'b1;
    case (state_reg)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_reg[0];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      idx_reg   <= 3'd0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      idx_reg   <= idx_next;
      tx_reg    <= tx_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= wdata[7:0];
  end

  // The shift register doubles as the registered read port of the FIFO array.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_reg <= 8'h00;
    end else if (pop) begin
      shift_reg <= mem[rd_ptr_reg[AW-1:0]];
    end else if (shift_en) begin
      shift_reg <= {1'b0, shift_reg[7:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (push_drop) begin
      ovf_reg <= 1'b1;
    end else if (ovf_clr) begin
      ovf_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_reg <= '0;
    end else if (re) begin
      rdata_reg <= addr ? status : 32'h0;
    end
  end

  assign rdata   = rdata_reg;
  assign uart_tx = tx_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected bytes/reads,
// while independent monitors decode the serial line and the read port.
module tb_uart_tx_fifo;
  localparam int CLK_HZ = 2500000;
  localparam int BAUD   = 115200;
  localparam int DEPTH  = 16;
  localparam int DIV    = CLK_HZ / BAUD;   // 21
  localparam int FRAME  = 10 * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic        addr = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        uart_tx;

  uart_tx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .re(re), .addr(addr),
    .wdata(wdata), .rdata(rdata), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  logic [7:0]  tx_exp[$];
  int          frame_starts[$];
  int          n_frames = 0;
  logic [31:0] rd_val[$];
  string       rd_name[$];

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
  endfunction

  // Read-port monitor: rdata is checked the cycle after re was sampled.
  logic re_q = 1'b0;
  always @(posedge clk) re_q <= re;
  always @(negedge clk) begin
    if (re_q) begin
      if (rd_val.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_read: got 0x%08h expected none", rdata);
      end else begin
        check(rd_name.pop_front(), rdata, rd_val.pop_front());
      end
    end
  end

  // Line monitor: decodes 8N1 frames and checks every bit is flat for DIV cycles.
  logic [9:0] mon_bits;
  logic       mon_flat, mon_abort;
  int         mon_start;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && uart_tx === 1'b0) begin
        mon_start = cyc;
        mon_abort = 1'b0;
        mon_flat  = 1'b1;
        mon_bits  = '0;
        for (int i = 0; i < FRAME; i++) begin
          if (i > 0) @(negedge clk);
          if (!rst_n) begin
            mon_abort = 1'b1;
            break;
          end
          if (i % DIV == 0) mon_bits[i / DIV] = uart_tx;
          else if (uart_tx !== mon_bits[i / DIV]) mon_flat = 1'b0;
        end
        if (!mon_abort) begin
          n_frames++;
          frame_starts.push_back(mon_start);
          check("frame_shape", {29'd0, mon_flat, mon_bits[0], mon_bits[9]}, 32'h5);
          if (tx_exp.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_frame: got 0x%02h expected none", mon_bits[8:1]);
          end else begin
            check("frame_data", {24'd0, mon_bits[8:1]}, {24'd0, tx_exp.pop_front()});
          end
        end
      end
    end
  end

  // One bus cycle starting and ending on a negedge; rexp queued when reading.
  task automatic op(input logic w, input logic r, input logic a, input logic [31:0] d,
                    input logic [31:0] rexp, input string nm);
    we = w; re = r; addr = a; wdata = d;
    if (r) begin
      rd_val.push_back(rexp);
      rd_name.push_back(nm);
    end
    @(posedge clk);
    @(negedge clk);
    we = 1'b0; re = 1'b0; addr = 1'b0; wdata = '0;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain(input int limit, input string nm);
    for (int i = 0; i < limit && tx_exp.size() != 0; i++) @(negedge clk);
    check(nm, tx_exp.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  int e, p, s0, s1, nf;

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    check("reset_tx", {31'd0, uart_tx}, 32'h1);
    rst_n = 1'b1;
    op(0, 1, 1, 0, 32'h0000_0002, "reset_status");

    // Single byte 0x55, TXDATA read in the same cycle returns 0
    e = cyc + 1;
    tx_exp.push_back(8'h55);
    op(1, 1, 0, 32'h55, 32'h0, "txdata_read");
    op(0, 1, 1, 0, 32'h0000_0104, "count_after_write");
    op(0, 1, 1, 0, 32'h0000_0006, "busy_mid_frame");
    wait_to(e + FRAME);
    op(0, 1, 1, 0, 32'h0000_0006, "busy_at_stop_end");
    op(0, 1, 1, 0, 32'h0000_0002, "busy_cleared");
    for (int i = 0; i < 8 && frame_starts.size() == 0; i++) @(negedge clk);
    check("start_latency", (frame_starts.size() != 0) ? frame_starts.pop_front() : -1, e + 2);
    drain(2 * FRAME, "drain_single");

    // Back-to-back 0xA5, 0x0F
    e = cyc + 1;
    tx_exp.push_back(8'hA5);
    tx_exp.push_back(8'h0F);
    op(1, 0, 0, 32'hA5, 0, "");
    op(1, 0, 0, 32'h0F, 0, "");
    drain(3 * FRAME, "drain_b2b");
    s0 = (frame_starts.size() != 0) ? frame_starts.pop_front() : -1;
    s1 = (frame_starts.size() != 0) ? frame_starts.pop_front() : -1;
    check("b2b_first_start", s0, e + 2);
    check("b2b_gap", s1 - s0, FRAME);

    // Overflow: 17 bytes with the first already popped
    nf = n_frames;
    e = cyc + 1;
    for (int k = 0; k < 17; k++) tx_exp.push_back(8'(8'h10 + k));
    for (int k = 0; k < 17; k++) op(1, 0, 0, 32'h10 + k, 0, "");
    op(0, 1, 1, 0, 32'h0000_1005, "full_status");
    op(1, 0, 0, 32'hEE, 0, "");
    op(0, 1, 1, 0, 32'h0000_100D, "ovf_set");
    op(1, 1, 1, 32'h8, 32'h0000_100D, "rw_same_cycle");
    op(0, 1, 1, 0, 32'h0000_1005, "ovf_cleared");

    // Push on a full FIFO coinciding with the STOP-end pop
    p = e + 1 + FRAME;
    wait_to(p - 2);
    op(0, 1, 1, 0, 32'h0000_1005, "pre_stop_end");
    op(1, 0, 0, 32'hCC, 0, "");
    op(0, 1, 1, 0, 32'h0000_0F0C, "full_push_pop");
    op(1, 0, 1, 32'h8, 0, "");
    drain(20 * FRAME, "drain_overflow");
    check("overflow_frames", n_frames - nf, 17);
    frame_starts.delete();
    op(0, 1, 1, 0, 32'h0000_0002, "drained_status");

    // Reset during d3 with 4 bytes still queued
    e = cyc + 1;
    for (int k = 0; k < 5; k++) begin
      tx_exp.push_back(8'(8'h31 + k));
      op(1, 0, 0, 32'h31 + k, 0, "");
    end
    wait_to(e + 2 + 4 * DIV + 4);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset_mid_tx", {31'd0, uart_tx}, 32'h1);
    tx_exp.delete();
    @(negedge clk);
    rst_n = 1'b1;
    nf = n_frames;
    op(0, 1, 1, 0, 32'h0000_0002, "reset_mid_status");
    repeat (3 * FRAME) @(negedge clk);
    check("no_frames_after_reset", n_frames - nf, 0);
    check("read_queue_empty", rd_val.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
